// File: rtl/step_pulse_gen.sv
// Debounced step button to single-cycle step strobe, with a wrapping step counter.
// Define STEP_AUTORUN_EN to build the free-running divider driven by run_sel.
module step_pulse_gen #(
    parameter int DB_CYCLES  = 500000,
    parameter int RUN_DIV    = 25000000,
    parameter int STEP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  button_n,
    input  logic                  run_sel,
    output logic                  step_en,
    output logic                  pressed,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic {IDLE, HELD} state_t;

    logic [1:0]            btn_sync_q;
    logic                  btn_smp_q;
    logic [DBW-1:0]        db_cnt_q, db_cnt_d;
    logic                  pressed_q, pressed_d;
    state_t                state_q;
    logic                  step_en_q;
    logic [STEP_CNT_W-1:0] step_cnt_q;
    logic                  run_active;
    logic                  auto_tick;
    logic                  manual_rise;

    // Sample register after the synchroniser sets the press latency to DB_CYCLES+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q <= 2'b11;
            btn_smp_q  <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button_n};
            btn_smp_q  <= ~btn_sync_q[1];
        end
    end

    always_comb begin
        db_cnt_d  = '0;
        pressed_d = pressed_q;
        if (btn_smp_q != pressed_q) begin
            if (db_cnt_q == DBW'(DB_CYCLES - 1)) begin
                pressed_d = btn_smp_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
        end
    end

`ifdef STEP_AUTORUN_EN
    localparam int DIVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    logic [1:0]      run_sync_q;
    logic            run_q;
    logic [DIVW-1:0] div_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sync_q <= 2'b00;
            run_q      <= 1'b0;
            div_q      <= '0;
        end else begin
            run_sync_q <= {run_sync_q[0], run_sel};
            run_q      <= run_sync_q[1];
            if (!run_q || auto_tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign run_active = run_q;
    assign auto_tick  = run_q && (div_q == DIVW'(RUN_DIV - 1));
`else
    logic unused_run_sel;
    assign unused_run_sel = run_sel;
    assign run_active     = 1'b0;
    assign auto_tick      = 1'b0;
`endif

    assign manual_rise = (state_q == IDLE) && pressed_q;

    // Manual and auto events merge into one strobe; back-to-back strobes are blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            step_en_q <= 1'b0;
        end else begin
            step_en_q <= ((manual_rise && !run_active) || auto_tick) && !step_en_q;
            case (state_q)
                IDLE:    if (pressed_q)  state_q <= HELD;
                HELD:    if (!pressed_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt_q <= '0;
        end else if (step_en_q) begin
            step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign step_en    = step_en_q;
    assign pressed    = pressed_q;
    assign step_count = step_cnt_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DB_CYCLES=4, RUN_DIV=8, STEP_CNT_W=4.
module tb_step_pulse_gen;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         button_n;
    logic         run_sel;
    logic         step_en;
    logic         pressed;
    logic [W-1:0] step_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         btn_n;
        logic         exp_step;
        logic         exp_pressed;
        logic [W-1:0] exp_cnt;
    } vec_t;

    vec_t tbl[20];

    step_pulse_gen #(.DB_CYCLES(DB), .RUN_DIV(RD), .STEP_CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .button_n   (button_n),
        .run_sel    (run_sel),
        .step_en    (step_en),
        .pressed    (pressed),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;

        rst      = 1'b1;
        button_n = 1'b1;
        run_sel  = 1'b0;
        #12;
        chk("reset_step_en", step_en, 0);
        chk("reset_pressed", pressed, 0);
        chk("reset_count", step_count, 0);
        rst = 1'b0;
        repeat (10) tick();

        // Clean press: pressed at edge 6, strobe after edge 7, count after edge 8.
        for (int i = 0; i < 20; i++) begin
            tbl[i].btn_n       = 1'b0;
            tbl[i].exp_step    = (i == 7);
            tbl[i].exp_pressed = (i >= 6);
            tbl[i].exp_cnt     = (i >= 8) ? W'(1) : W'(0);
        end
        for (int i = 0; i < 20; i++) begin
            button_n = tbl[i].btn_n;
            tick();
            chk($sformatf("press_step[%0d]", i), step_en, tbl[i].exp_step);
            chk($sformatf("press_pressed[%0d]", i), pressed, tbl[i].exp_pressed);
            chk($sformatf("press_cnt[%0d]", i), step_count, tbl[i].exp_cnt);
        end

        for (int i = 0; i < 10; i++) begin
            button_n = 1'b1;
            tick();
            chk($sformatf("release_pressed[%0d]", i), pressed, (i < 6));
            chk($sformatf("release_step[%0d]", i), step_en, 0);
        end

        // Bounce: 2-cycle runs never reach DB; stable low from edge 12.
        for (int i = 0; i < 30; i++) begin
            button_n = (i < 12) ? logic'((i / 2) % 2) : 1'b0;
            tick();
            chk($sformatf("bounce_step[%0d]", i), step_en, (i == 19));
        end
        chk("bounce_count", step_count, 2);
        button_n = 1'b1;
        repeat (10) tick();

        // Asynchronous reset with the button released.
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_step_en", step_en, 0);
        chk("midreset_pressed", pressed, 0);
        chk("midreset_count", step_count, 0);
        #2;
        rst = 1'b0;
        repeat (5) tick();

        // Wrap: 17 presses on a 4-bit counter.
        pulses = 0;
        for (int p = 0; p < 17; p++) begin
            button_n = 1'b0;
            for (int k = 0; k < 10; k++) begin tick(); if (step_en) pulses++; end
            button_n = 1'b1;
            for (int k = 0; k < 10; k++) begin tick(); if (step_en) pulses++; end
        end
        chk("wrap_pulses", pulses, 17);
        chk("wrap_count", step_count, 1);

        // Reset landing on a strobe cycle, button held through reset release.
        button_n = 1'b0;
        repeat (8) tick();
        chk("hold_step_before_rst", step_en, 1);
        chk("hold_pressed_before_rst", pressed, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("hold_rst_step_en", step_en, 0);
        chk("hold_rst_pressed", pressed, 0);
        chk("hold_rst_count", step_count, 0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("hold_step[%0d]", i), step_en, (i == 7));
            chk($sformatf("hold_pressed[%0d]", i), pressed, (i >= 6));
        end
        chk("hold_count", step_count, 1);
        button_n = 1'b1;
        repeat (12) tick();

`ifdef STEP_AUTORUN_EN
        // Auto steps at edges 10,18,26,34; manual press mid-run is suppressed.
        for (int i = 0; i < 40; i++) begin
            run_sel  = 1'b1;
            button_n = (i >= 12 && i < 30) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("auto_step[%0d]", i), step_en, (i >= 10) && ((i - 10) % RD == 0));
        end
`else
        for (int i = 0; i < 40; i++) begin
            run_sel = 1'b1;
            tick();
            chk($sformatf("noauto_step[%0d]", i), step_en, 0);
        end
`endif
        run_sel  = 1'b0;
        button_n = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
